// File: rtl/mc_pkg.sv
// mc_pkg: shared types and constants for the multi-cycle MIPS controller.
//   state_t  : FSM state encoding (also driven out on the state port)
//   ALU_*    : ALUctr encodings
//   OP_*/FN_*: opcode and R-type function codes
//   ctrl_t   : decoded per-instruction controls held by the FSM
package mc_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNC_W  = 6;
    localparam int unsigned ALU_W   = 3;
    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_t;

    localparam logic [ALU_W-1:0] ALU_ADDU = 3'b000;
    localparam logic [ALU_W-1:0] ALU_ADD  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_OR   = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUBU = 3'b011;
    localparam logic [ALU_W-1:0] ALU_SUB  = 3'b100;
    localparam logic [ALU_W-1:0] ALU_SLT  = 3'b101;
    localparam logic [ALU_W-1:0] ALU_SLTU = 3'b110;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FUNC_W-1:0] FN_ADDU = 6'b100001;
    localparam logic [FUNC_W-1:0] FN_ADD  = 6'b100000;
    localparam logic [FUNC_W-1:0] FN_SUBU = 6'b100011;
    localparam logic [FUNC_W-1:0] FN_SUB  = 6'b100010;
    localparam logic [FUNC_W-1:0] FN_SLT  = 6'b101010;
    localparam logic [FUNC_W-1:0] FN_SLTU = 6'b101011;

    // Controls held stable from the cycle after DECODE until the next DECODE.
    typedef struct packed {
        logic [ALU_W-1:0] alu_ctr;
        logic             ext_op;
        logic             alu_src;
        logic             reg_dst;
        logic             mem_to_reg;  // lw: also selects the MEM -> WB path
        logic             mem_wr;      // sw
        logic             is_beq;
        logic             ov_chk;      // add/sub/addi suppress RegWr on overflow
    } ctrl_t;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: purely combinational op/func decoder.
//   op, func : instruction fields from the datapath
//   ctrl     : decoded control struct (all zero for j and illegal encodings)
//   is_j     : instruction is j
//   illegal  : unsupported op, or unsupported func for R-type
module mc_decode
    import mc_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [FUNC_W-1:0] func,
    output ctrl_t             ctrl,
    output logic              is_j,
    output logic              illegal
);

    always_comb begin
        ctrl    = '0;
        is_j    = 1'b0;
        illegal = 1'b0;
        unique case (op)
            OP_RTYPE: begin
                ctrl.reg_dst = 1'b1;
                unique case (func)
                    FN_ADDU: ctrl.alu_ctr = ALU_ADDU;
                    FN_ADD: begin
                        ctrl.alu_ctr = ALU_ADD;
                        ctrl.ov_chk  = 1'b1;
                    end
                    FN_SUBU: ctrl.alu_ctr = ALU_SUBU;
                    FN_SUB: begin
                        ctrl.alu_ctr = ALU_SUB;
                        ctrl.ov_chk  = 1'b1;
                    end
                    FN_SLT:  ctrl.alu_ctr = ALU_SLT;
                    FN_SLTU: ctrl.alu_ctr = ALU_SLTU;
                    default: begin
                        ctrl    = '0;
                        illegal = 1'b1;
                    end
                endcase
            end
            OP_ORI: begin
                ctrl.alu_ctr = ALU_OR;
                ctrl.alu_src = 1'b1;
            end
            OP_ADDIU: begin
                ctrl.alu_ctr = ALU_ADDU;
                ctrl.alu_src = 1'b1;
                ctrl.ext_op  = 1'b1;
            end
            OP_ADDI: begin
                ctrl.alu_ctr = ALU_ADD;
                ctrl.alu_src = 1'b1;
                ctrl.ext_op  = 1'b1;
                ctrl.ov_chk  = 1'b1;
            end
            OP_LW: begin
                ctrl.alu_ctr    = ALU_ADDU;
                ctrl.alu_src    = 1'b1;
                ctrl.ext_op     = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_ctr = ALU_ADDU;
                ctrl.alu_src = 1'b1;
                ctrl.ext_op  = 1'b1;
                ctrl.mem_wr  = 1'b1;
            end
            OP_BEQ: begin
                ctrl.alu_ctr = ALU_SUBU;
                ctrl.ext_op  = 1'b1;
                ctrl.is_beq  = 1'b1;
            end
            OP_J:    is_j    = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle MIPS datapath.
// Optional feature macro: MULTICYCLE_CTRL_PERF_EN (adds cycle_cnt / instr_cnt outputs).
// Ports:
//   clk, rst (sync, active high)
//   op, func             : instruction fields from the instruction register
//   zero                 : ALU zero (consumed by the IFU directly, unused here)
//   overflow             : ALU overflow, captured at the end of EXEC
//   mem_ready            : data memory completes the access this cycle
//   RegWr..jump, ALUctr  : datapath controls
//   PCWr, IRWr           : IFU next-PC enable, instruction register load
//   state                : current FSM state
//   trap                 : sticky illegal-instruction / memory-timeout flag
//   cycle_cnt, instr_cnt : performance counters (macro builds only)
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNC_W-1:0]  func,
    input  logic               zero,
    input  logic               overflow,
    input  logic               mem_ready,
    output logic               RegWr,
    output logic               ExtOp,
    output logic               ALUsrc,
    output logic               MemWr,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               branch,
    output logic               jump,
    output logic [ALU_W-1:0]   ALUctr,
    output logic               PCWr,
    output logic               IRWr,
    output logic [STATE_W-1:0] state,
    output logic               trap
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0]        cycle_cnt,
    output logic [31:0]        instr_cnt
`endif
);

    localparam int unsigned WAIT_W = 8;

    state_t            cur_state;
    state_t            nxt_state;
    ctrl_t             dec_c;
    ctrl_t             dec_q;
    logic              is_j_c;
    logic              illegal_c;
    logic              ov_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_c;

    // The IFU consumes zero itself; the port exists so one bus feeds both blocks.
    logic unused_zero;
    assign unused_zero = zero;

    mc_decode u_decode (
        .op      (op),
        .func    (func),
        .ctrl    (dec_c),
        .is_j    (is_j_c),
        .illegal (illegal_c)
    );

    // Last allowed wait cycle: the next not-ready cycle would exceed the budget.
    assign timeout_c = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= ST_FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state logic.
    always_comb begin
        nxt_state = cur_state;
        unique case (cur_state)
            ST_FETCH: nxt_state = ST_DECODE;
            ST_DECODE: begin
                if (illegal_c) begin
                    nxt_state = ST_TRAP;
                end else if (is_j_c) begin
                    nxt_state = ST_FETCH;
                end else begin
                    nxt_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (dec_q.is_beq) begin
                    nxt_state = ST_FETCH;
                end else if (dec_q.mem_to_reg || dec_q.mem_wr) begin
                    nxt_state = ST_MEM;
                end else begin
                    nxt_state = ST_WB;
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    nxt_state = dec_q.mem_wr ? ST_FETCH : ST_WB;
                end else if (timeout_c) begin
                    nxt_state = ST_TRAP;
                end
            end
            ST_WB:   nxt_state = ST_FETCH;
            ST_TRAP: nxt_state = ST_TRAP;
            default: nxt_state = ST_FETCH;
        endcase
    end

    // Strobe outputs; all forced low while rst is asserted.
    // In DECODE the registered controls are not loaded yet, so j uses the live decode.
    always_comb begin
        IRWr   = 1'b0;
        PCWr   = 1'b0;
        RegWr  = 1'b0;
        MemWr  = 1'b0;
        branch = 1'b0;
        jump   = 1'b0;
        trap   = 1'b0;
        if (!rst) begin
            unique case (cur_state)
                ST_FETCH: IRWr = 1'b1;
                ST_DECODE: begin
                    if (is_j_c && !illegal_c) begin
                        PCWr = 1'b1;
                        jump = 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (dec_q.is_beq) begin
                        PCWr   = 1'b1;
                        branch = 1'b1;
                    end
                end
                ST_MEM: begin
                    MemWr = dec_q.mem_wr;
                    PCWr  = dec_q.mem_wr && mem_ready;
                end
                ST_WB: begin
                    RegWr = !(dec_q.ov_chk && ov_q);
                    PCWr  = 1'b1;
                end
                ST_TRAP: trap = 1'b1;
                default: ;
            endcase
        end
    end

    // Decoded-control, overflow and MEM wait-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q    <= '0;
            ov_q     <= 1'b0;
            wait_cnt <= '0;
        end else begin
            if (cur_state == ST_DECODE && !illegal_c) begin
                dec_q <= dec_c;
            end
            if (cur_state == ST_EXEC) begin
                ov_q <= overflow;
            end
            if (cur_state == ST_MEM && !mem_ready) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    assign state    = cur_state;
    assign ALUctr   = dec_q.alu_ctr;
    assign ExtOp    = dec_q.ext_op;
    assign ALUsrc   = dec_q.alu_src;
    assign RegDst   = dec_q.reg_dst;
    assign MemtoReg = dec_q.mem_to_reg;

`ifdef MULTICYCLE_CTRL_PERF_EN
    // Free-running counters, frozen once the controller traps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else if (cur_state != ST_TRAP) begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (PCWr) begin
                instr_cnt <= instr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl.
// Strobe vector order: {IRWr, PCWr, RegWr, MemWr, branch, jump}; expectations are {state, strobes}.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic [5:0] func;
    logic       zero;
    logic       overflow;
    logic       mem_ready;
    logic       RegWr, ExtOp, ALUsrc, MemWr, RegDst, MemtoReg, branch, jump;
    logic [2:0] ALUctr;
    logic       PCWr, IRWr;
    logic [2:0] state;
    logic       trap;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    wire [5:0] strb = {IRWr, PCWr, RegWr, MemWr, branch, jump};

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .func      (func),
        .zero      (zero),
        .overflow  (overflow),
        .mem_ready (mem_ready),
        .RegWr     (RegWr),
        .ExtOp     (ExtOp),
        .ALUsrc    (ALUsrc),
        .MemWr     (MemWr),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .branch    (branch),
        .jump      (jump),
        .ALUctr    (ALUctr),
        .PCWr      (PCWr),
        .IRWr      (IRWr),
        .state     (state),
        .trap      (trap)
`ifdef MULTICYCLE_CTRL_PERF_EN
        ,
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; op = 6'b0; func = 6'b0; zero = 1'b0; overflow = 1'b0; mem_ready = 1'b0;
        tick();
        tick();
        #1;
        checks++;
        if ({state, strb} !== 9'b0) begin
            failures++;
            $display("FAIL reset_state: got %b want %b", {state, strb}, 9'b0);
        end
        checks++;
        if ({ALUctr, ExtOp, ALUsrc, RegDst, MemtoReg, trap} !== 8'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b want %b", {ALUctr, ExtOp, ALUsrc, RegDst, MemtoReg, trap}, 8'b0);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({state, strb} !== 9'b000_100000) begin
            failures++;
            $display("FAIL reset_release: got %b want %b", {state, strb}, 9'b000_100000);
        end
    endtask

    task automatic test_addu();
        logic [8:0] exp [0:3];
        exp = '{9'b000_100000, 9'b001_000000, 9'b010_000000, 9'b100_011000};
        op = 6'b000000; func = 6'b100001; overflow = 1'b0; mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if ({state, strb} !== exp[k]) begin
                failures++;
                $display("FAIL addu_cyc%0d: got %b want %b", k, {state, strb}, exp[k]);
            end
            if (k == 2) begin
                checks++;
                if (ALUctr !== 3'b000) begin
                    failures++;
                    $display("FAIL addu_aluctr: got %b want %b", ALUctr, 3'b000);
                end
            end
            if (k == 3) begin
                checks++;
                if ({RegDst, MemtoReg, ALUsrc} !== 3'b100) begin
                    failures++;
                    $display("FAIL addu_regdst: got %b want %b", {RegDst, MemtoReg, ALUsrc}, 3'b100);
                end
            end
            tick();
        end
    endtask

    task automatic test_lw_wait();
        logic [8:0] exp [0:6];
        exp = '{9'b000_100000, 9'b001_000000, 9'b010_000000, 9'b011_000000,
                9'b011_000000, 9'b011_000000, 9'b100_011000};
        op = 6'b100011; func = 6'b000000; overflow = 1'b0;
        for (int k = 0; k < 7; k++) begin
            mem_ready = (k == 5);
            #1;
            checks++;
            if ({state, strb} !== exp[k]) begin
                failures++;
                $display("FAIL lw_cyc%0d: got %b want %b", k, {state, strb}, exp[k]);
            end
            if (k == 6) begin
                checks++;
                if ({MemtoReg, ALUsrc, ExtOp, RegDst, ALUctr} !== 7'b1110_000) begin
                    failures++;
                    $display("FAIL lw_ctrl: got %b want %b", {MemtoReg, ALUsrc, ExtOp, RegDst, ALUctr}, 7'b1110_000);
                end
            end
            tick();
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [5:0] ops  [0:3];
        logic [5:0] fns  [0:3];
        logic       ovs  [0:3];
        logic [5:0] wbs  [0:3];
        ops = '{6'b000000, 6'b000000, 6'b000000, 6'b001000};
        fns = '{6'b100000, 6'b100000, 6'b100001, 6'b000000};
        ovs = '{1'b1, 1'b0, 1'b1, 1'b1};
        wbs = '{6'b010000, 6'b011000, 6'b011000, 6'b010000};
        mem_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            op = ops[t]; func = fns[t];
            for (int k = 0; k < 4; k++) begin
                overflow = (k == 2) ? ovs[t] : 1'b0;
                #1;
                if (k == 2 && t == 0) begin
                    checks++;
                    if (ALUctr !== 3'b001) begin
                        failures++;
                        $display("FAIL add_aluctr: got %b want %b", ALUctr, 3'b001);
                    end
                end
                if (k == 3) begin
                    checks++;
                    if ({state, strb} !== {3'd4, wbs[t]}) begin
                        failures++;
                        $display("FAIL ov_case%0d_wb: got %b want %b", t, {state, strb}, {3'd4, wbs[t]});
                    end
                end
                tick();
            end
        end
        overflow = 1'b0;
    endtask

    task automatic test_beq_j();
        logic [8:0] eb [0:2];
        logic [8:0] ej [0:1];
        eb = '{9'b000_100000, 9'b001_000000, 9'b010_010010};
        ej = '{9'b000_100000, 9'b001_010001};
        op = 6'b000100; func = 6'b000000; mem_ready = 1'b0; zero = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if ({state, strb} !== eb[k]) begin
                failures++;
                $display("FAIL beq_cyc%0d: got %b want %b", k, {state, strb}, eb[k]);
            end
            if (k == 2) begin
                checks++;
                if ({ALUctr, ExtOp, ALUsrc} !== 5'b011_10) begin
                    failures++;
                    $display("FAIL beq_ctrl: got %b want %b", {ALUctr, ExtOp, ALUsrc}, 5'b011_10);
                end
            end
            tick();
        end
        op = 6'b000010; zero = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if ({state, strb} !== ej[k]) begin
                failures++;
                $display("FAIL j_cyc%0d: got %b want %b", k, {state, strb}, ej[k]);
            end
            tick();
        end
    endtask

    task automatic test_ori_sw();
        logic [8:0] eo [0:3];
        logic [8:0] es [0:4];
        eo = '{9'b000_100000, 9'b001_000000, 9'b010_000000, 9'b100_011000};
        es = '{9'b000_100000, 9'b001_000000, 9'b010_000000, 9'b011_000100, 9'b011_010100};
        op = 6'b001101; func = 6'b000000; mem_ready = 1'b0; overflow = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if ({state, strb} !== eo[k]) begin
                failures++;
                $display("FAIL ori_cyc%0d: got %b want %b", k, {state, strb}, eo[k]);
            end
            if (k == 2) begin
                checks++;
                if ({ALUctr, ExtOp, ALUsrc, RegDst} !== 6'b010_010) begin
                    failures++;
                    $display("FAIL ori_ctrl: got %b want %b", {ALUctr, ExtOp, ALUsrc, RegDst}, 6'b010_010);
                end
            end
            tick();
        end
        // mem_ready is high outside MEM and must be ignored there
        op = 6'b101011;
        for (int k = 0; k < 5; k++) begin
            mem_ready = (k != 3);
            #1;
            checks++;
            if ({state, strb} !== es[k]) begin
                failures++;
                $display("FAIL sw_cyc%0d: got %b want %b", k, {state, strb}, es[k]);
            end
            tick();
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_rst_mid();
        op = 6'b101011; mem_ready = 1'b0;
        tick(); tick(); tick();
        #1;
        checks++;
        if ({state, MemWr} !== 4'b011_1) begin
            failures++;
            $display("FAIL rstmid_in_mem: got %b want %b", {state, MemWr}, 4'b011_1);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (strb !== 6'b0) begin
            failures++;
            $display("FAIL rstmid_strobes: got %b want %b", strb, 6'b0);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({state, strb} !== 9'b000_100000) begin
            failures++;
            $display("FAIL rstmid_fetch: got %b want %b", {state, strb}, 9'b000_100000);
        end
        tick();
        do_reset();
    endtask

    task automatic test_timeout();
        int memwr_cycles;
        memwr_cycles = 0;
        op = 6'b101011; mem_ready = 1'b0;
        tick(); tick(); tick();
        for (int k = 0; k < 15; k++) begin
            #1;
            if (state == 3'd3 && MemWr === 1'b1) memwr_cycles++;
            tick();
        end
        checks++;
        if (memwr_cycles != 15) begin
            failures++;
            $display("FAIL timeout_mem_cycles: got %0d want %0d", memwr_cycles, 15);
        end
        for (int k = 0; k < 4; k++) begin
            mem_ready = (k > 0);
            #1;
            checks++;
            if ({state, strb, trap} !== 10'b111_000000_1) begin
                failures++;
                $display("FAIL timeout_trap%0d: got %b want %b", k, {state, strb, trap}, 10'b111_000000_1);
            end
            tick();
        end
        mem_ready = 1'b0;
        do_reset();
        #1;
        checks++;
        if ({state, trap, MemWr} !== 5'b000_00) begin
            failures++;
            $display("FAIL timeout_reset: got %b want %b", {state, trap, MemWr}, 5'b000_00);
        end
    endtask

    task automatic test_illegal();
        logic [5:0] ops [0:1];
        logic [5:0] fns [0:1];
        ops = '{6'b111111, 6'b000000};
        fns = '{6'b100001, 6'b000000};
        mem_ready = 1'b0;
        for (int t = 0; t < 2; t++) begin
            op = ops[t]; func = fns[t];
            #1;
            checks++;
            if ({state, strb} !== 9'b000_100000) begin
                failures++;
                $display("FAIL ill%0d_fetch: got %b want %b", t, {state, strb}, 9'b000_100000);
            end
            tick();
            #1;
            checks++;
            if ({state, strb} !== 9'b001_000000) begin
                failures++;
                $display("FAIL ill%0d_decode: got %b want %b", t, {state, strb}, 9'b001_000000);
            end
            tick();
            // legal op and mem_ready afterwards must not release the trap
            op = 6'b000000; func = 6'b100001; mem_ready = 1'b1;
            for (int k = 0; k < 5; k++) begin
                #1;
                checks++;
                if ({state, strb, trap} !== 10'b111_000000_1) begin
                    failures++;
                    $display("FAIL ill%0d_trap%0d: got %b want %b", t, k, {state, strb, trap}, 10'b111_000000_1);
                end
                tick();
            end
            checks++;
            if ({RegDst, ALUctr} !== 4'b0) begin
                failures++;
                $display("FAIL ill%0d_ctrl: got %b want %b", t, {RegDst, ALUctr}, 4'b0);
            end
            mem_ready = 1'b0;
            do_reset();
        end
    endtask

`ifdef MULTICYCLE_CTRL_PERF_EN
    task automatic test_perf();
        do_reset();
        mem_ready = 1'b1; overflow = 1'b0;
        op = 6'b000000; func = 6'b100001;
        for (int k = 0; k < 4; k++) tick();
        op = 6'b100011;
        for (int k = 0; k < 5; k++) tick();
        op = 6'b000010;
        for (int k = 0; k < 2; k++) tick();
        checks++;
        if ({cycle_cnt, instr_cnt} !== {32'd11, 32'd3}) begin
            failures++;
            $display("FAIL perf_counts: got cycles=%0d instrs=%0d want cycles=11 instrs=3", cycle_cnt, instr_cnt);
        end
        mem_ready = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_addu();
        test_lw_wait();
        test_overflow();
        test_beq_j();
        test_ori_sw();
        test_rst_mid();
        test_timeout();
        test_illegal();
`ifdef MULTICYCLE_CTRL_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
